// File: rtl/seg7_pkg.sv
// seg7_pkg -- shared definitions for the 7-segment display blocks.
//
// Holds the segment pattern of every hex digit ({g,f,e,d,c,b,a}, 1 = lit),
// the blank pattern, the reader FSM state type and the hex-to-segment
// encoder function. The encoder and the decoder both work from these
// constants, so the two directions always agree.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_A     = 7'b1110111;
  localparam logic [6:0] SEG_B     = 7'b1111100;
  localparam logic [6:0] SEG_C     = 7'b0111001;
  localparam logic [6:0] SEG_D     = 7'b1011110;
  localparam logic [6:0] SEG_E     = 7'b1111001;
  localparam logic [6:0] SEG_F     = 7'b1110001;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,  // no digit collected yet
    ST_COLLECT = 2'd1,  // some, but not all, digits collected
    ST_EMIT    = 2'd2   // frame just published (one cycle)
  } state_t;

  // Hex-to-segment encoder used by the display driver side.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
    logic [6:0] pat;
    case (hex)
      4'h0: pat = SEG_0;
      4'h1: pat = SEG_1;
      4'h2: pat = SEG_2;
      4'h3: pat = SEG_3;
      4'h4: pat = SEG_4;
      4'h5: pat = SEG_5;
      4'h6: pat = SEG_6;
      4'h7: pat = SEG_7;
      4'h8: pat = SEG_8;
      4'h9: pat = SEG_9;
      4'hA: pat = SEG_A;
      4'hB: pat = SEG_B;
      4'hC: pat = SEG_C;
      4'hD: pat = SEG_D;
      4'hE: pat = SEG_E;
      default: pat = SEG_F;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode -- combinational segment-pattern to hex-nibble decoder.
//
// Ports:
//   pattern  in  7  segment lines {g,f,e,d,c,b,a}, 1 = lit
//   nibble   out 4  decoded hex value (0 when not decodable)
//   valid    out 1  pattern is one of the 16 hex glyphs
//   blank    out 1  pattern has no segment lit
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] nibble,
  output logic       valid,
  output logic       blank
);

  always_comb begin
    nibble = 4'h0;
    valid  = 1'b1;
    blank  = (pattern == SEG_BLANK);
    case (pattern)
      SEG_0:   nibble = 4'h0;
      SEG_1:   nibble = 4'h1;
      SEG_2:   nibble = 4'h2;
      SEG_3:   nibble = 4'h3;
      SEG_4:   nibble = 4'h4;
      SEG_5:   nibble = 4'h5;
      SEG_6:   nibble = 4'h6;
      SEG_7:   nibble = 4'h7;
      SEG_8:   nibble = 4'h8;
      SEG_9:   nibble = 4'h9;
      SEG_A:   nibble = 4'hA;
      SEG_B:   nibble = 4'hB;
      SEG_C:   nibble = 4'hC;
      SEG_D:   nibble = 4'hD;
      SEG_E:   nibble = 4'hE;
      SEG_F:   nibble = 4'hF;
      default: valid  = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_reader.sv
// seg7_reader -- recovers the hex value shown on a multiplexed 4-digit
// 7-segment display by snooping its segment and digit-enable lines.
//
// Each {seg,dig_en} pair must be seen unchanged for STABLE_CYCLES samples
// before it counts as a digit. Captured digits are collected per slot;
// once all four slots are filled the frame is published on data with a
// one-cycle data_valid pulse. An undecodable glyph aborts the frame and
// pulses err.
//
// Ports:
//   clk         in  1   clock, rising edge
//   rst         in  1   synchronous active-high reset
//   seg         in  7   segment lines {g,f,e,d,c,b,a}, 1 = lit
//   dig_en      in  4   one-hot digit enable, bit i = digit i
//   data        out 16  last complete frame, digit i in data[4i+3:4i]
//   data_valid  out 1   pulse when data is updated
//   err         out 1   pulse when an undecodable glyph is captured
module seg7_reader
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg,
  input  logic [3:0]  dig_en,
  output logic [15:0] data,
  output logic        data_valid,
  output logic        err
);

  localparam int              CW      = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_MAX = CW'(STABLE_CYCLES);

  // ---------------------------------------------------------------
  // Stability filter
  // ---------------------------------------------------------------
  logic [10:0]   pair;
  logic          pair_ok;
  logic [10:0]   sample_reg;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          fresh_reg, fresh_next;

  assign pair    = {seg, dig_en};
  assign pair_ok = $onehot(dig_en);

  always_comb begin
    cnt_next = cnt_reg;
    if (!pair_ok) begin
      cnt_next = '0;
    end else if (pair != sample_reg) begin
      cnt_next = CW'(1);
    end else if (cnt_reg != CNT_MAX) begin
      cnt_next = cnt_reg + CW'(1);
    end
    // Fires only on the transition into saturation, so a long hold yields
    // exactly one capture.
    fresh_next = pair_ok && (cnt_next == CNT_MAX) && (cnt_reg != CNT_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sample_reg <= '0;
      cnt_reg    <= '0;
      fresh_reg  <= 1'b0;
    end else begin
      sample_reg <= pair;
      cnt_reg    <= cnt_next;
      fresh_reg  <= fresh_next;
    end
  end

  // ---------------------------------------------------------------
  // Capture decode. While fresh_reg is high, sample_reg still holds the
  // pair that completed the hold, and its dig_en field is one-hot.
  // ---------------------------------------------------------------
  logic [3:0] cap_nibble;
  logic       cap_valid;
  logic       cap_blank;
  logic [3:0] cap_sel;

  assign cap_sel = sample_reg[3:0];

  seg7_decode u_decode (
    .pattern (sample_reg[10:4]),
    .nibble  (cap_nibble),
    .valid   (cap_valid),
    .blank   (cap_blank)
  );

  // ---------------------------------------------------------------
  // Frame collection FSM
  // ---------------------------------------------------------------
  state_t      state_reg, state_next;
  logic [3:0]  mask_reg, mask_next;
  logic [15:0] data_reg, data_next;
  logic        data_valid_reg, data_valid_next;
  logic        err_reg, err_next;
  logic        slot_we;
  logic [3:0]  slot_reg  [4];
  logic [3:0]  slot_next [4];
  logic [15:0] frame;

  // Captures landing in EMIT are dropped; blanks never count.
  assign slot_we = fresh_reg && !cap_blank && cap_valid && (state_reg != ST_EMIT);

  for (genvar gi = 0; gi < 4; gi++) begin : g_slot
    assign slot_next[gi]      = (slot_we && cap_sel[gi]) ? cap_nibble : slot_reg[gi];
    assign frame[4*gi +: 4]   = slot_next[gi];

    always_ff @(posedge clk) begin
      if (rst) begin
        slot_reg[gi] <= 4'h0;
      end else begin
        slot_reg[gi] <= slot_next[gi];
      end
    end
  end

  always_comb begin
    state_next      = state_reg;
    mask_next       = mask_reg;
    data_next       = data_reg;
    data_valid_next = 1'b0;
    err_next        = 1'b0;

    case (state_reg)
      ST_EMIT: begin
        state_next = ST_IDLE;
      end
      default: begin
        if (fresh_reg && !cap_blank) begin
          if (!cap_valid) begin
            err_next   = 1'b1;
            mask_next  = 4'b0000;
            state_next = ST_IDLE;
          end else if ((mask_reg | cap_sel) == 4'b1111) begin
            // Completing digit: publish the frame including this nibble.
            data_next       = frame;
            data_valid_next = 1'b1;
            mask_next       = 4'b0000;
            state_next      = ST_EMIT;
          end else begin
            mask_next  = mask_reg | cap_sel;
            state_next = ST_COLLECT;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      mask_reg       <= 4'b0000;
      data_reg       <= 16'h0000;
      data_valid_reg <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      mask_reg       <= mask_next;
      data_reg       <= data_next;
      data_valid_reg <= data_valid_next;
      err_reg        <= err_next;
    end
  end

  assign data       = data_reg;
  assign data_valid = data_valid_reg;
  assign err        = err_reg;

endmodule

// File: tb/tb_seg7_reader.sv
// tb_seg7_reader -- directed stimulus with a scoreboard queue. The stimulus
// process pushes each expected event (frame or error) together with the
// cycle it must appear in; a monitor on the falling edge pops and compares
// every data_valid / err pulse the DUT produces.
module tb_seg7_reader;

  // Hand-written glyph table {g,f,e,d,c,b,a}
  localparam logic [6:0] P0 = 7'h3F, P1 = 7'h06, P2 = 7'h5B, P3 = 7'h4F;
  localparam logic [6:0] P4 = 7'h66, P5 = 7'h6D, P7 = 7'h07, P8 = 7'h7F;
  localparam logic [6:0] PA = 7'h77, PB = 7'h7C, PC = 7'h39, PD = 7'h5E;
  localparam logic [6:0] PE = 7'h79, PF = 7'h71, BAD = 7'h55, BLANK = 7'h00;

  typedef struct {
    bit          is_err;
    logic [15:0] d;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  seg = 7'h00;
  logic [3:0]  dig_en = 4'h0;
  logic [15:0] data;
  logic        data_valid;
  logic        err;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  seg7_reader #(.STABLE_CYCLES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .seg        (seg),
    .dig_en     (dig_en),
    .data       (data),
    .data_valid (data_valid),
    .err        (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Drive a pair for n rising edges; returns #1 after the last edge.
  task automatic hold(input logic [6:0] s, input logic [3:0] e, input int n);
    seg    = s;
    dig_en = e;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called right after a hold whose last edge completed a capture:
  // the event must be visible in the following cycle.
  task automatic expect_ev(input bit is_err, input logic [15:0] d);
    exp_t e;
    e.is_err = is_err;
    e.d      = d;
    e.cyc    = cyc + 1;
    q.push_back(e);
    $display("push %s data=%h at cycle %0d", is_err ? "err  " : "frame", d, e.cyc);
  endtask

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end else begin
      $display("ok   %s = %h", name, got);
    end
  endtask

  // Hold one 4-cycle digit on slot idx.
  task automatic dig(input int idx, input logic [6:0] s);
    hold(s, 4'(1 << idx), 4);
  endtask

  task automatic idle(input int n);
    hold(BLANK, 4'h0, n);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (data_valid && err) begin
        checks++;
        errors++;
        $display("FAIL exclusive: data_valid and err both high at cycle %0d", cyc);
      end
      if (data_valid || err) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected: data_valid=%0b err=%0b data=%h at cycle %0d",
                   data_valid, err, data, cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          if ((e.is_err != err) || (e.is_err == data_valid) ||
              (!e.is_err && data !== e.d) || (cyc != e.cyc)) begin
            errors++;
            $display("FAIL event: got valid=%0b err=%0b data=%h cycle=%0d want %s data=%h cycle=%0d",
                     data_valid, err, data, cyc, e.is_err ? "err" : "frame", e.d, e.cyc);
          end else begin
            $display("ok   event %s data=%h cycle=%0d", e.is_err ? "err" : "frame", data, cyc);
          end
        end
      end
    end
  end

  initial begin
    // Reset state
    idle(3);
    chk("reset_data", data, 16'h0000);
    chk("reset_valid", {15'd0, data_valid}, 16'h0000);
    chk("reset_err", {15'd0, err}, 16'h0000);
    rst = 1'b0;
    idle(2);

    // Digits 3..0 = 1,2,3,4
    dig(3, P1); dig(2, P2); dig(1, P3); dig(0, P4);
    expect_ev(1'b0, 16'h1234);
    idle(4);
    chk("frame_1234", data, 16'h1234);

    // Too-short hold: no capture
    hold(P8, 4'b0001, 3);
    idle(6);
    chk("short_hold_keeps", data, 16'h1234);

    // Undecodable glyph aborts the frame
    dig(0, P1); dig(1, P2); dig(2, BAD);
    expect_ev(1'b1, 16'h0000);
    idle(3);
    chk("err_keeps_data", data, 16'h1234);
    dig(0, PA); dig(1, PB); dig(2, PC); dig(3, PD);
    expect_ev(1'b0, 16'hDCBA);
    idle(3);
    chk("frame_dcba", data, 16'hDCBA);

    // Invalid digit enables
    hold(P0, 4'b0110, 10);
    hold(P0, 4'b0000, 10);
    chk("bad_dig_en", data, 16'hDCBA);

    // Re-capture overwrites slot 1
    dig(1, P5); dig(1, P7); dig(0, P0); dig(2, P0); dig(3, P0);
    expect_ev(1'b0, 16'h0070);
    idle(3);
    chk("overwrite", data, 16'h0070);

    // Blank digit is ignored
    dig(0, P1); dig(1, BLANK); dig(1, P2); dig(2, P3); dig(3, P4);
    expect_ev(1'b0, 16'h4321);
    idle(3);
    chk("blank_ignored", data, 16'h4321);

    // Long hold of a bad glyph: a single err only
    hold(BAD, 4'b0100, 4);
    expect_ev(1'b1, 16'h0000);
    hold(BAD, 4'b0100, 8);
    idle(3);
    chk("long_hold", data, 16'h4321);

    // Reset mid-frame, then a bad glyph straddling reset release
    dig(0, P1); dig(1, P2); dig(2, P3);
    rst = 1'b1;
    hold(BAD, 4'b1000, 2);
    chk("midreset_data", data, 16'h0000);
    chk("midreset_valid", {15'd0, data_valid}, 16'h0000);
    chk("midreset_err", {15'd0, err}, 16'h0000);
    rst = 1'b0;
    hold(BAD, 4'b1000, 3);
    dig(3, PF); dig(2, PE); dig(1, PE); dig(0, PD);
    expect_ev(1'b0, 16'hFEED);
    idle(5);
    chk("frame_feed", data, 16'hFEED);

    // Every expected event must have been consumed
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL pending: %0d expected events never seen, want 0", q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_reader.md
SEG7_READER -- requirements
Module: seg7_reader

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, range 2..255: consecutive identical samples required before a digit is captured.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 seg  input  7  segment lines {g,f,e,d,c,b,a} = seg[6:0], active-high (1 = lit).
REQ-005 dig_en  input  4  digit enable of a multiplexed 4-digit display, one-hot, bit i = digit i (digit 0 = least significant nibble).
REQ-006 data  output  16  last complete decoded frame, digit i in data[4i+3:4i].
REQ-007 data_valid  output  1  single-cycle pulse when data is updated.
REQ-008 err  output  1  single-cycle pulse on capture of an undecodable pattern.

Function
REQ-009 Decode table (seg[6:0]): 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111, A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001.
REQ-010 Stability filter: {seg,dig_en} registered each cycle; counter increments while the registered pair equals the previous one, restarts at 1 on any change.
REQ-011 Capture occurs on the cycle the counter reaches STABLE_CYCLES; counter saturates, exactly one capture per stable hold.
REQ-012 dig_en zero or multi-hot: no capture, counter held at 0, no err.
REQ-013 seg = 0000000 (blank) with valid dig_en: no capture, no err, collected digits unaffected.
REQ-014 Capture of a pattern not in REQ-009 and not blank: err pulses the cycle after capture; frame discarded (mask cleared, state IDLE).
REQ-015 Capture of a valid pattern: nibble stored in slot i, mask bit i set; re-capture of slot i before frame completion overwrites the nibble.
REQ-016 FSM states: IDLE (mask empty), COLLECT (mask nonzero, not full), EMIT (one cycle). IDLE->COLLECT on first valid capture; COLLECT->EMIT when mask becomes 1111; EMIT->IDLE unconditionally.
REQ-017 In EMIT: data loaded from the four slots, data_valid = 1, mask cleared; latency = 1 cycle after the completing capture.
REQ-018 Capture coinciding with EMIT is ignored (filter continues; the hold is not re-captured).
REQ-019 data holds its value between frames; data_valid and err never asserted together.
REQ-020 Counter width ceil(log2(STABLE_CYCLES+1)); no wrap-around of the counter.

Reset
REQ-021 On rst: data = 16'h0000, data_valid = 0, err = 0, mask = 0000, slots = 0, counter = 0, sample register cleared, state IDLE.
REQ-022 rst asserted mid-frame discards all partially collected digits; first capture after release requires a full STABLE_CYCLES hold sampled after release.

Structure
REQ-023 Shared package seg7_pkg holds the 16 pattern constants of REQ-009, the BLANK constant and the FSM state type; the existing hex-to-segment encoder is updated to use the same constants.
REQ-024 Combinational sub-module seg7_decode (pattern in -> nibble + valid flag out) used once inside seg7_reader.

Verification
REQ-025 Drive digits 3,2,1,0 with patterns of 1,2,3,4 each held 4 cycles -> data = 16'h1234, data_valid one pulse 1 cycle after the last capture.
REQ-026 Hold digit 0 pattern 8 for 3 cycles, then change -> no capture, mask stays 0000, no data_valid.
REQ-027 Capture digits 0,1 valid, then digit 2 with 1010101 -> err single pulse, no data_valid, subsequent full scan of A,b,C,d yields data = 16'hdCbA.
REQ-028 dig_en = 0110 or 0000 for 10 cycles with pattern 0 -> no capture, no err.
REQ-029 Digit 1 captured as 5 then 7 within one frame, others 0 -> data = 16'h0070.
REQ-030 rst pulsed after 3 of 4 digits captured -> outputs at reset values, next complete scan of F,E,E,D on digits 3..0 gives 16'hFEED only.
